instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader and write-side counterpart of the instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-addressed instruction store as four little-endian byte writes at consecutive addresses. It holds the core in reset (`cpu_hold`) while loading, so a program can be placed in memory without hard-coding it in RTL.

## Interface
Parameters:
- `ADDR_W`, 8: width of byte address and word counter.
- `MEM_BYTES`, 128: instruction store size in bytes; must be a multiple of 4.
- `BASE_ADDR`, 0: first byte address written; must be word-aligned.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load session; ignored while `busy`.
- `word_valid` in 1: `word_data`/`word_last` valid.
- `word_data` in 32: instruction word; bits 7:0 go to the lowest address.
- `word_last` in 1: marks the final word of the program.
- `word_ready` out 1: loader accepts a word this cycle.
- `mem_we` out 1: byte write strobe to the instruction store, sampled on rising `clk`.
- `mem_addr` out ADDR_W: byte write address.
- `mem_wdata` out 8: byte write data.
- `busy` out 1: session in progress.
- `cpu_hold` out 1: equals `busy`; drives the core's reset.
- `done` out 1: sticky; program fully written.
- `overflow` out 1: sticky; a word would exceed `MEM_BYTES`.
- `words_loaded` out ADDR_W: words completely written this session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE.
- IDLE:
  - `word_ready`=0 and `busy`=0.
  - On `start`: load the address register with `BASE_ADDR`, clear `done`, `overflow` and `words_loaded`, go to ACCEPT.
- ACCEPT:
  - `word_ready`=1 and `busy`=1.
  - On `word_valid`: latch `word_data` and `word_last`.
  - If addr+4 > `MEM_BYTES`: set `overflow`, write nothing, go to IDLE.
  - Otherwise: clear the 2-bit byte index and go to WRITE.
- WRITE:
  - `mem_we`=1, `mem_addr`=addr+idx, `mem_wdata`=word[8*idx+7 : 8*idx].
  - idx increments each cycle, 0 to 3.
  - After idx=3: addr += 4 and `words_loaded` += 1.
  - If the latched last flag is set: set `done` and go to IDLE. Otherwise go to ACCEPT.
- `mem_*` outputs are decoded only from registers, never from inputs. When `mem_we`=0, `mem_addr`/`mem_wdata` are 0.
- Address arithmetic is ADDR_W-bit unsigned. The overflow check uses ADDR_W+1 bits, so the address register never wraps.
- A `start` pulse in ACCEPT or WRITE is ignored.
- A new `start` after `done` or `overflow` begins a fresh session from `BASE_ADDR`.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `word_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `cpu_hold`, `done`, `overflow`, `words_loaded` all go to 0.
  - A partially written word stays in memory as-is; no further writes occur.
- `start` sampled at edge S puts ACCEPT (`word_ready`=1) in the cycle after S.
- A handshake at edge E0 (`word_valid` & `word_ready`) produces:
  - `mem_we`=1 in the four cycles after E0; bytes are committed at edges E1..E4.
  - `words_loaded` updated at E4.
  - `word_ready`=1 again in the cycle after E4 (non-last word).
  - Or `done`=1 and `busy`=0 in the cycle after E4 (last word).
- Throughput is one word per 5 cycles with `word_valid` held high.
- `word_valid` low in ACCEPT means no write and no state change.
- Overflow: handshake at E0, then `overflow`=1 and `busy`=0 in the cycle after E0, with no `mem_we` pulse.

## Structure
- Shared `riscv_pkg`: FSM state encoding, `BYTES_PER_WORD`=4.
- Single module; the byte-lane select is an inline 4:1 mux. No sub-module.
- The instruction memory gains a synchronous byte write port (`mem_we`/`mem_addr`/`mem_wdata`); its read path is unchanged.

## Test plan
- Single word: reset, `start`, word 0x00940333 with `word_last`=1 → writes 0x33@0, 0x03@1, 0x94@2, 0x00@3 on four consecutive edges. Then `done`=1, `words_loaded`=1, `cpu_hold`=0.
- Stalled stream: words 0x800100b3 then 0x00209133 (last), with `word_valid` low for 3 cycles between them → bytes b3,00,01,80 @4..7 and 33,91,20,00 @8..11. No `mem_we` during the gap; `words_loaded`=3.
- Overflow: `MEM_BYTES`=8, three words → the first two are written at 0..7. The third is accepted with no write; `overflow`=1, `done`=0, `words_loaded`=2.
- Reset mid-WRITE after byte idx 1 → `mem_we` drops immediately and all outputs are 0. A following `start` reloads from `BASE_ADDR`=0.
- `start` pulsed during WRITE is ignored (address sequence unchanged). `start` after `done` clears `done` and the next word writes at `BASE_ADDR`.
- `BASE_ADDR`=16, one word 0x00a08513 → writes 0x13@16, 0x85@17, 0xa0@18, 0x00@19.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-side blocks: loader FSM encoding
// and the word/byte geometry of the instruction store.
package riscv_pkg;

    // Loader session states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2
    } load_state_t;

    // An instruction word occupies four consecutive byte addresses.
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;

    // Byte index of the final (most significant) lane of a word.
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

endpackage

// File: rtl/instruction_loader.sv
// Program loader: takes 32-bit instruction words from a valid/ready stream
// and writes each one into the byte-addressed instruction store as four
// little-endian byte writes. The core is held in reset while a session runs.
module instruction_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 128,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_loaded
);

    // The bounds check is done one bit wider than the address so that
    // addr+4 can never wrap around and slip under the limit.
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   WORD_SPAN = (ADDR_W+1)'(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    load_state_t       state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        idx_reg;
    logic [31:0]       word_reg;
    logic              last_reg;

    logic              word_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic [ADDR_W-1:0] words_loaded_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;

    logic [1:0]        idx_next;
    logic [7:0]        byte_next;
    logic              would_overflow;
    logic [7:0]        lane [BYTES_PER_WORD];

    // Split the latched word into its byte lanes, lane 0 = lowest address.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lane[gi] = word_reg[BYTE_W*gi +: BYTE_W];
        end
    endgenerate

    assign idx_next       = idx_reg + 2'd1;
    assign would_overflow = ({1'b0, addr_reg} + WORD_SPAN) > MEM_LIMIT;

    // Byte lane for the next write cycle: plain 4:1 mux on the next index.
    always_comb begin
        byte_next = lane[0];
        case (idx_next)
            2'd0:    byte_next = lane[0];
            2'd1:    byte_next = lane[1];
            2'd2:    byte_next = lane[2];
            default: byte_next = lane[3];
        endcase
    end

    // Session FSM; every output is a register so the store's write port
    // never sees a combinational path from the input stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            idx_reg          <= '0;
            word_reg         <= '0;
            last_reg         <= 1'b0;
            word_ready_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            overflow_reg     <= 1'b0;
            words_loaded_reg <= '0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg         <= BASE;
                        done_reg         <= 1'b0;
                        overflow_reg     <= 1'b0;
                        words_loaded_reg <= '0;
                        word_ready_reg   <= 1'b1;
                        busy_reg         <= 1'b1;
                        state_reg        <= ST_ACCEPT;
                    end
                end

                ST_ACCEPT: begin
                    if (word_valid) begin
                        word_reg       <= word_data;
                        last_reg       <= word_last;
                        word_ready_reg <= 1'b0;
                        if (would_overflow) begin
                            // Word is swallowed without touching memory.
                            overflow_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            // First byte goes out straight from the handshake
                            // cycle so four writes follow back to back.
                            idx_reg       <= 2'd0;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= addr_reg;
                            mem_wdata_reg <= word_data[7:0];
                            state_reg     <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (idx_reg == LAST_BYTE_IDX) begin
                        mem_we_reg       <= 1'b0;
                        mem_addr_reg     <= '0;
                        mem_wdata_reg    <= '0;
                        addr_reg         <= addr_reg + ADDR_STEP;
                        words_loaded_reg <= words_loaded_reg + ADDR_W'(1);
                        if (last_reg) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            word_ready_reg <= 1'b1;
                            state_reg      <= ST_ACCEPT;
                        end
                    end else begin
                        idx_reg       <= idx_next;
                        mem_addr_reg  <= addr_reg + ADDR_W'(idx_next);
                        mem_wdata_reg <= byte_next;
                    end
                end

                default: begin
                    word_ready_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    mem_we_reg     <= 1'b0;
                    mem_addr_reg   <= '0;
                    mem_wdata_reg  <= '0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_ready   = word_ready_reg;
    assign busy         = busy_reg;
    assign cpu_hold     = busy_reg;
    assign done         = done_reg;
    assign overflow     = overflow_reg;
    assign words_loaded = words_loaded_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: three instances (default store, 8-byte
// store, base address 16), a byte-write logger per instance, a word-level
// reference model, a table of directed sessions, hand-written corner
// sequences and randomized sessions.
module tb_instruction_loader;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start        [3];
    logic          word_valid   [3];
    logic [31:0]   word_data    [3];
    logic          word_last    [3];
    logic          word_ready   [3];
    logic          mem_we       [3];
    logic [AW-1:0] mem_addr     [3];
    logic [7:0]    mem_wdata    [3];
    logic          busy         [3];
    logic          cpu_hold     [3];
    logic          done         [3];
    logic          overflow     [3];
    logic [AW-1:0] words_loaded [3];

    instruction_loader #(.ADDR_W(AW), .MEM_BYTES(128), .BASE_ADDR(0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .word_valid(word_valid[0]),
        .word_data(word_data[0]), .word_last(word_last[0]), .word_ready(word_ready[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .busy(busy[0]), .cpu_hold(cpu_hold[0]), .done(done[0]),
        .overflow(overflow[0]), .words_loaded(words_loaded[0]));

    instruction_loader #(.ADDR_W(AW), .MEM_BYTES(8), .BASE_ADDR(0)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .word_valid(word_valid[1]),
        .word_data(word_data[1]), .word_last(word_last[1]), .word_ready(word_ready[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .busy(busy[1]), .cpu_hold(cpu_hold[1]), .done(done[1]),
        .overflow(overflow[1]), .words_loaded(words_loaded[1]));

    instruction_loader #(.ADDR_W(AW), .MEM_BYTES(128), .BASE_ADDR(16)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .word_valid(word_valid[2]),
        .word_data(word_data[2]), .word_last(word_last[2]), .word_ready(word_ready[2]),
        .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .busy(busy[2]), .cpu_hold(cpu_hold[2]), .done(done[2]),
        .overflow(overflow[2]), .words_loaded(words_loaded[2]));

    function automatic int base_of(input int d);
        return (d == 2) ? 16 : 0;
    endfunction

    function automatic int mem_of(input int d);
        return (d == 1) ? 8 : 128;
    endfunction

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Byte writes observed on each store port, in commit order.
    logic [15:0] wlog [3][256];
    int          wcnt [3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (mem_we[d]) begin
                if (wcnt[d] < 256) wlog[d][wcnt[d]] = {mem_addr[d], mem_wdata[d]};
                wcnt[d]++;
            end else begin
                chk("bus_zero_when_idle", {16'h0, mem_addr[d], mem_wdata[d]}, 32'h0);
            end
        end
    end

    // Reference model: word i lands at base+4i..base+4i+3 unless it would
    // run past the end of the store, in which case the session stops there.
    logic [31:0] sw [8];
    logic [15:0] exp_log [256];
    int          exp_cnt;
    int          exp_ovf_idx;
    logic        exp_done;
    logic        exp_ovf;
    int          exp_wl;

    task automatic model(input int d, input int n);
        exp_cnt = 0; exp_ovf_idx = -1; exp_done = 1'b0; exp_ovf = 1'b0; exp_wl = 0;
        for (int i = 0; i < n; i++) begin
            if (base_of(d) + 4 * (i + 1) > mem_of(d)) begin
                exp_ovf = 1'b1;
                exp_ovf_idx = i;
                break;
            end
            for (int k = 0; k < 4; k++) begin
                exp_log[exp_cnt] = {8'(base_of(d) + 4 * i + k), 8'(sw[i] >> (8 * k))};
                exp_cnt++;
            end
            exp_wl++;
            if (i == n - 1) exp_done = 1'b1;
        end
    endtask

    // One load session on instance d with n words from sw[], gap idle
    // cycles between words; optionally pulses start during the first word.
    task automatic run_session(input int d, input int n, input int gap, input bit start_mid);
        model(d, n);
        wcnt[d] = 0;
        start[d] = 1'b1;
        tick;
        start[d] = 1'b0;
        chk("ready_after_start", word_ready[d], 1);
        chk("busy_after_start", busy[d], 1);
        chk("hold_after_start", cpu_hold[d], 1);
        chk("done_cleared", done[d], 0);
        chk("overflow_cleared", overflow[d], 0);
        chk("loaded_cleared", words_loaded[d], 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick;
                    chk("gap_no_write", mem_we[d], 0);
                    chk("gap_ready_held", word_ready[d], 1);
                end
            end
            word_valid[d] = 1'b1;
            word_data[d]  = sw[i];
            word_last[d]  = (i == n - 1);
            begin
                int b = 0;
                while (!word_ready[d] && b < 20) begin
                    tick;
                    b++;
                end
            end
            if (!word_ready[d]) begin
                chk("ready_timeout", 0, 1);
                word_valid[d] = 1'b0;
                break;
            end
            tick;
            word_valid[d] = 1'b0;
            word_data[d]  = $urandom;
            word_last[d]  = 1'($urandom);
            if (i == exp_ovf_idx) begin
                chk("overflow_set", overflow[d], 1);
                chk("overflow_busy", busy[d], 0);
                chk("overflow_no_write", mem_we[d], 0);
                chk("overflow_done", done[d], 0);
                break;
            end
            for (int c = 0; c < 4; c++) begin
                chk("write_cycle_we", mem_we[d], 1);
                chk("write_cycle_ready", word_ready[d], 0);
                chk("loaded_before_e4", words_loaded[d], i);
                if (start_mid && i == 0) start[d] = (c == 1);
                tick;
            end
            start[d] = 1'b0;
            chk("we_after_e4", mem_we[d], 0);
            chk("loaded_after_e4", words_loaded[d], i + 1);
            if (i == n - 1) begin
                chk("done_after_last", done[d], 1);
                chk("busy_after_last", busy[d], 0);
                chk("hold_after_last", cpu_hold[d], 0);
            end else begin
                chk("ready_after_word", word_ready[d], 1);
                chk("busy_mid_session", busy[d], 1);
            end
        end
        tick;
        chk("idle_ready", word_ready[d], 0);
        chk("write_count", wcnt[d], exp_cnt);
        for (int j = 0; j < exp_cnt; j++) chk("write_addr_data", wlog[d][j], exp_log[j]);
        chk("final_done", done[d], exp_done);
        chk("final_overflow", overflow[d], exp_ovf);
        chk("final_loaded", words_loaded[d], exp_wl);
        $display("session dut%0d words=%0d gap=%0d writes=%0d done=%0d overflow=%0d loaded=%0d",
                 d, n, gap, wcnt[d], done[d], overflow[d], words_loaded[d]);
    endtask

    typedef struct {
        int          d;
        int          n;
        logic [31:0] w0, w1, w2, w3;
        int          gap;
        logic        e_done;
        logic        e_ovf;
        int          e_wl;
        int          e_first_addr;
    } vec_t;

    function automatic vec_t mk(input int d, input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input int gap,
                                input logic e_done, input logic e_ovf, input int e_wl, input int e_fa);
        vec_t v;
        v.d = d; v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.gap = gap;
        v.e_done = e_done; v.e_ovf = e_ovf; v.e_wl = e_wl; v.e_first_addr = e_fa;
        return v;
    endfunction

    vec_t tbl [5];

    initial begin
        tbl[0] = mk(0, 1, 32'h00940333, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1, 0);
        tbl[1] = mk(0, 3, 32'h00940333, 32'h800100b3, 32'h00209133, 32'h0, 3, 1'b1, 1'b0, 3, 0);
        tbl[2] = mk(1, 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 0, 1'b0, 1'b1, 2, 0);
        tbl[3] = mk(2, 1, 32'h00a08513, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1, 16);
        tbl[4] = mk(1, 2, 32'hdeadbeef, 32'hcafef00d, 32'h0, 32'h0, 1, 1'b1, 1'b0, 2, 0);

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; word_valid[d] = 1'b0; word_data[d] = '0; word_last[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", word_ready[d], 0);
            chk("reset_we", mem_we[d], 0);
            chk("reset_busy", busy[d], 0);
            chk("reset_hold", cpu_hold[d], 0);
            chk("reset_done", done[d], 0);
            chk("reset_overflow", overflow[d], 0);
            chk("reset_loaded", words_loaded[d], 0);
        end
        reset = 1'b0;
        tick;

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            sw[0] = tbl[t].w0; sw[1] = tbl[t].w1; sw[2] = tbl[t].w2; sw[3] = tbl[t].w3;
            run_session(tbl[t].d, tbl[t].n, tbl[t].gap, 1'b0);
            chk("tbl_done", done[tbl[t].d], tbl[t].e_done);
            chk("tbl_overflow", overflow[tbl[t].d], tbl[t].e_ovf);
            chk("tbl_loaded", words_loaded[tbl[t].d], tbl[t].e_wl);
            chk("tbl_first_addr", wlog[tbl[t].d][0][15:8], tbl[t].e_first_addr);
        end

        // Reset during WRITE after byte indices 0 and 1 have been committed.
        wcnt[0] = 0;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        word_valid[0] = 1'b1; word_data[0] = 32'h11223344; word_last[0] = 1'b1;
        tick;
        word_valid[0] = 1'b0;
        tick;
        tick;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", mem_we[0], 0);
        chk("rst_mid_addr", mem_addr[0], 0);
        chk("rst_mid_wdata", mem_wdata[0], 0);
        chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_hold", cpu_hold[0], 0);
        chk("rst_mid_loaded", words_loaded[0], 0);
        #1;
        reset = 1'b0;
        tick;
        tick;
        chk("rst_mid_writes", wcnt[0], 2);
        chk("rst_mid_byte0", wlog[0][0], 16'h0044);
        chk("rst_mid_byte1", wlog[0][1], 16'h0133);
        $display("session dut0 reset-mid-write writes=%0d", wcnt[0]);
        sw[0] = 32'h55667788;
        run_session(0, 1, 0, 1'b0);

        // start pulsed during WRITE, then a fresh session right after done.
        sw[0] = 32'h0a0b0c0d; sw[1] = 32'h01020304;
        run_session(0, 2, 0, 1'b1);
        sw[0] = 32'hfeedface;
        run_session(0, 1, 0, 1'b0);

        // Randomized sessions on the roomy store and the 8-byte store.
        for (int r = 0; r < 16; r++) begin
            int d;
            int n;
            d = r % 2;
            n = $urandom_range(1, 5);
            for (int i = 0; i < 8; i++) sw[i] = $urandom;
            run_session(d, n, $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
